// File: rtl/comb_bist_pkg.sv
// Shared types and default truth tables for the comb block self-test controller.
package comb_bist_pkg;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned ERR_W = 4;
  localparam int unsigned VEC_W = 3;

  // Controller phases: waiting, holding a vector, sampling it, reporting
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Bit k holds the expected output for {a,b,c} == k
  localparam logic [7:0] G_EXP_DEF = 8'b0110_1001;
  localparam logic [7:0] H_EXP_DEF = 8'b1011_1010;
  localparam logic [7:0] I_EXP_DEF = 8'b1110_1011;

endpackage

// File: rtl/comb_bist_ctrl.sv
// Exhaustive self-test sequencer for the 3-input combinational comb block.
module comb_bist_ctrl
  import comb_bist_pkg::*;
#(
  parameter int unsigned SETTLE = 2,
  parameter logic [7:0]  G_EXP  = G_EXP_DEF,
  parameter logic [7:0]  H_EXP  = H_EXP_DEF,
  parameter logic [7:0]  I_EXP  = I_EXP_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [2:0]       abc,
  input  logic [2:0]       ghi,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [2:0]       first_fail,
  output logic [2:0]       fail_mask
);

  state_e             state_q, state_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         abc_q, abc_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [2:0]         ff_q, ff_d;
  logic [2:0]         fm_q, fm_d;
  logic [2:0]         exp_ghi;
  logic [2:0]         mism;

  // State and result registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      abc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ff_q    <= '0;
      fm_q    <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      abc_q   <= abc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      fm_q    <= fm_d;
    end
  end

  // Next-state, result update and registered-output decode
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    err_d   = err_q;
    ff_d    = ff_q;
    fm_d    = fm_q;
    exp_ghi = {G_EXP[vec_q], H_EXP[vec_q], I_EXP[vec_q]};
    mism    = ghi ^ exp_ghi;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_d   = '0;
          ff_d    = '0;
          fm_d    = '0;
          pass_d  = 1'b0;
          vec_d   = '0;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(SETTLE - 1)) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (mism != 3'b000) begin
          err_d = err_q + ERR_W'(1);
          if (err_q == '0) begin
            ff_d = vec_q;
            fm_d = mism;
          end
        end
        if (vec_q == VEC_W'(7)) begin
          state_d = ST_DONE;
        end else begin
          vec_d   = vec_q + VEC_W'(1);
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_DONE: begin
        pass_d  = (err_q == '0);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_SETTLE) || (state_d == ST_CHECK);
    done_d = (state_d == ST_DONE);
    abc_d  = busy_d ? vec_d : 3'b000;
  end

  assign abc        = abc_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign first_fail = ff_q;
  assign fail_mask  = fm_q;

endmodule

// File: tb/tb_comb_bist_ctrl.sv
// Directed bench for comb_bist_ctrl with a behavioural comb model on ghi.
module tb_comb_bist_ctrl;
  import comb_bist_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] abc;
  logic [2:0] ghi;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_count;
  logic [2:0] first_fail;
  logic [2:0] fail_mask;

  int n_tests = 0;
  int n_fail  = 0;
  int mode    = 0;   // 0: good comb, 1: g inverted at vector 3, 2: stuck at 000

  logic [7:0] g_tab = 8'b0110_1001;
  logic [7:0] h_tab = 8'b1011_1010;
  logic [7:0] i_tab = 8'b1110_1011;

  comb_bist_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abc        (abc),
    .ghi        (ghi),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .first_fail (first_fail),
    .fail_mask  (fail_mask)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the comb block
  always_comb begin
    case (mode)
      1:       ghi = {g_tab[abc] ^ (abc == 3'd3), h_tab[abc], i_tab[abc]};
      2:       ghi = 3'b000;
      default: ghi = {g_tab[abc], h_tab[abc], i_tab[abc]};
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One run: start sampled in the current cycle (cycle 0), observe cycles 1..28
  task automatic run_capture(input bit repulse, output int done_cyc, output int done_cnt,
                             output int busy_bad, output int abc_bad, output logic pass_c1);
    done_cyc = -1;
    done_cnt = 0;
    busy_bad = 0;
    abc_bad  = 0;
    pass_c1  = 1'bx;
    start = 1'b1;
    step();
    for (int c = 1; c <= 28; c++) begin
      if (c == 1) pass_c1 = pass;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (busy !== ((c >= 1) && (c <= 24))) busy_bad++;
      if (abc !== ((c <= 24) ? 3'((c - 1) / 3) : 3'd0)) abc_bad++;
      start = repulse && ((c == 5) || (c == 25));
      step();
    end
    start = 1'b0;
  endtask

  int   dcyc, dcnt, bbad, abad;
  logic p1;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    step();
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_abc", 32'(abc), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    check("rst_ff", 32'(first_fail), 32'd0);
    check("rst_fm", 32'(fail_mask), 32'd0);
    reset = 1'b0;
    step();

    // Good comb: full pass, timing of abc/busy/done
    mode = 0;
    run_capture(1'b0, dcyc, dcnt, bbad, abad, p1);
    check("good_done_cycle", 32'(dcyc), 32'd25);
    check("good_done_count", 32'(dcnt), 32'd1);
    check("good_busy_profile", 32'(bbad), 32'd0);
    check("good_abc_profile", 32'(abad), 32'd0);
    check("good_pass", 32'(pass), 32'd1);
    check("good_err", 32'(err_count), 32'd0);
    check("good_ff", 32'(first_fail), 32'd0);
    check("good_fm", 32'(fail_mask), 32'd0);

    // g wrong only at vector 3
    mode = 1;
    run_capture(1'b0, dcyc, dcnt, bbad, abad, p1);
    check("inv_pass_cleared", 32'(p1), 32'd0);
    check("inv_done_cycle", 32'(dcyc), 32'd25);
    check("inv_err", 32'(err_count), 32'd1);
    check("inv_ff", 32'(first_fail), 32'd3);
    check("inv_fm", 32'(fail_mask), 32'd4);
    check("inv_pass", 32'(pass), 32'd0);

    // ghi stuck at 000: only vector 2 matches
    mode = 2;
    run_capture(1'b0, dcyc, dcnt, bbad, abad, p1);
    check("stuck_err", 32'(err_count), 32'd7);
    check("stuck_ff", 32'(first_fail), 32'd0);
    check("stuck_fm", 32'(fail_mask), 32'd5);
    check("stuck_pass", 32'(pass), 32'd0);

    // start re-pulsed at cycles 5 and 25 is ignored
    mode = 0;
    run_capture(1'b1, dcyc, dcnt, bbad, abad, p1);
    check("repulse_done_cycle", 32'(dcyc), 32'd25);
    check("repulse_done_count", 32'(dcnt), 32'd1);
    check("repulse_busy_profile", 32'(bbad), 32'd0);
    check("repulse_pass", 32'(pass), 32'd1);
    check("repulse_err", 32'(err_count), 32'd0);

    // Reset mid-run at cycle 10 with stuck ghi (vectors 0,1 failed by then)
    mode = 2;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 10; c++) step();
    check("mid_err_before_reset", 32'(err_count), 32'd2);
    check("mid_busy_before_reset", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_abc", 32'(abc), 32'd0);
    check("mid_rst_err", 32'(err_count), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    step();
    mode = 0;
    run_capture(1'b0, dcyc, dcnt, bbad, abad, p1);
    check("post_rst_done_cycle", 32'(dcyc), 32'd25);
    check("post_rst_abc_profile", 32'(abad), 32'd0);
    check("post_rst_pass", 32'(pass), 32'd1);
    check("post_rst_err", 32'(err_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
